// File: rtl/validated_burst_buffer_if.sv
// validated_burst_buffer_if: push, commit, drain and burst handshake bundle; fwd_* exist only with BURST_BUFFER_FORWARD_EN
interface validated_burst_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH      = 64
);
  logic                    push_i;
  logic [DATA_WIDTH-1:0]   data_i;
  logic [TAG_WIDTH-1:0]    tag_i;
  logic                    full_o;
  logic                    empty_o;
  logic [$clog2(DEPTH):0]  size_o;
  logic                    valid_i;
  logic [TAG_WIDTH-1:0]    valid_tag_i;
  logic                    drain_i;
  logic                    burst_valid_o;
  logic                    burst_ready_i;
  logic [DATA_WIDTH-1:0]   data_o;
  logic                    burst_last_o;
`ifdef BURST_BUFFER_FORWARD_EN
  logic [TAG_WIDTH-1:0]    fwd_tag_i;
  logic                    fwd_hit_o;
  logic [DATA_WIDTH-1:0]   fwd_data_o;
`endif
  modport slave (
`ifdef BURST_BUFFER_FORWARD_EN
    input fwd_tag_i, output fwd_hit_o, output fwd_data_o,
`endif
    input push_i, data_i, tag_i, valid_i, valid_tag_i, drain_i, burst_ready_i,
    output full_o, empty_o, size_o, burst_valid_o, data_o, burst_last_o
  );
  modport master (
`ifdef BURST_BUFFER_FORWARD_EN
    output fwd_tag_i, input fwd_hit_o, input fwd_data_o,
`endif
    output push_i, data_i, tag_i, valid_i, valid_tag_i, drain_i, burst_ready_i,
    input full_o, empty_o, size_o, burst_valid_o, data_o, burst_last_o
  );
endinterface

// File: rtl/validated_burst_buffer.sv
// validated_burst_buffer: tagged store queue emitting bursts of committed head entries; BURST_BUFFER_FORWARD_EN adds a tag-lookup forwarding port
module validated_burst_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int TAG_WIDTH  = 6,
  parameter int BURST_LEN  = 4
) (
  input logic clk_i,
  input logic rst_n_i,
  input logic flush_i,
  validated_burst_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  typedef enum logic {IDLE, BURST} state_t;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag [DEPTH];
  logic [AW-1:0]         off [DEPTH];
  logic [DEPTH-1:0]      committed, live;
  logic [AW-1:0]         push_ptr, pull_ptr;
  logic [CW-1:0]         count;
  logic [BW-1:0]         beat_count, run;
  logic                  drain_pending, push_ok, pull, next_head_committed;
  state_t                state;
  assign bus.full_o  = count == CW'(DEPTH);
  assign bus.empty_o = count == '0;
  assign bus.size_o  = count;
  assign bus.data_o  = mem_data[pull_ptr];
  assign push_ok     = bus.push_i && !bus.full_o;
  assign pull        = bus.burst_valid_o && bus.burst_ready_i;
  for (genvar i = 0; i < DEPTH; i++) begin : g_live
    assign off[i]  = AW'(i) - pull_ptr;
    assign live[i] = {1'b0, off[i]} < count;
  end
  assign next_head_committed = live[pull_ptr + AW'(1)] && committed[pull_ptr + AW'(1)];
  // Length of the committed run starting at the head, capped at one full burst
  always_comb begin
    logic stop;
    run  = '0;
    stop = 1'b0;
    for (int k = 0; k < BURST_LEN; k++) begin
      if (!stop && live[pull_ptr + AW'(k)] && committed[pull_ptr + AW'(k)]) run = run + 1'b1;
      else stop = 1'b1;
    end
  end
  // Payload storage; liveness and committed bits qualify it, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_data[push_ptr] <= bus.data_i;
      mem_tag[push_ptr]  <= bus.tag_i;
    end
  end
  // Pointers wrap naturally; count disambiguates full from empty
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      push_ptr <= '0;
      pull_ptr <= '0;
      count    <= '0;
    end else if (flush_i) begin
      push_ptr <= '0;
      pull_ptr <= '0;
      count    <= '0;
    end else begin
      push_ptr <= push_ptr + AW'(push_ok);
      pull_ptr <= pull_ptr + AW'(pull);
      count    <= count + CW'(push_ok) - CW'(pull);
    end
  end
  // Writeback marks matching live entries committed; a fresh push starts uncommitted
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) committed <= '0;
    else if (flush_i) committed <= '0;
    else begin
      for (int k = 0; k < DEPTH; k++)
        if (bus.valid_i && live[k] && mem_tag[k] == bus.valid_tag_i) committed[k] <= 1'b1;
      if (push_ok) committed[push_ptr] <= 1'b0;
    end
  end
  // Drain stays requested until the queue empties or a burst ends at an uncommitted head
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) drain_pending <= 1'b0;
    else if (flush_i) drain_pending <= 1'b0;
    else if (bus.drain_i) drain_pending <= 1'b1;
    else if (bus.empty_o || (pull && bus.burst_last_o && !next_head_committed)) drain_pending <= 1'b0;
  end
  // Burst sequencer; length is locked when the burst starts
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      beat_count        <= '0;
      bus.burst_valid_o <= 1'b0;
      bus.burst_last_o  <= 1'b0;
    end else if (flush_i) begin
      state             <= IDLE;
      beat_count        <= '0;
      bus.burst_valid_o <= 1'b0;
      bus.burst_last_o  <= 1'b0;
    end else if (state == IDLE) begin
      if (run == BW'(BURST_LEN) || (drain_pending && run != '0)) begin
        state             <= BURST;
        beat_count        <= run;
        bus.burst_valid_o <= 1'b1;
        bus.burst_last_o  <= run == BW'(1);
      end
    end else if (pull) begin
      beat_count       <= beat_count - 1'b1;
      bus.burst_last_o <= beat_count == BW'(2);
      if (bus.burst_last_o) begin
        state             <= IDLE;
        bus.burst_valid_o <= 1'b0;
        bus.burst_last_o  <= 1'b0;
      end
    end
  end
`ifdef BURST_BUFFER_FORWARD_EN
  // Tag lookup over live entries, including one being pulled this cycle
  always_comb begin
    bus.fwd_hit_o  = 1'b0;
    bus.fwd_data_o = '0;
    for (int k = 0; k < DEPTH; k++)
      if (live[k] && mem_tag[k] == bus.fwd_tag_i) begin
        bus.fwd_hit_o  = 1'b1;
        bus.fwd_data_o = mem_data[k];
      end
  end
`endif
endmodule

// File: tb/tb_validated_burst_buffer.sv
// tb_validated_burst_buffer: scoreboard bench for validated_burst_buffer
module tb_validated_burst_buffer;
  localparam int DW = 32, DEPTH = 8, TW = 6, BL = 4;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stop = 1'b0;
  int checks = 0, failures = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  logic hold = 1'b0, hold_l;
  logic [DW-1:0] hold_d;
  always #5 clk = ~clk;
  validated_burst_buffer_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus();
  validated_burst_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .bus(bus)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.push_i = 1'b1; bus.tag_i = t; bus.data_i = d;
    tick();
    bus.push_i = 1'b0;
  endtask
  task automatic commit(input logic [TW-1:0] t);
    bus.valid_i = 1'b1; bus.valid_tag_i = t;
    tick();
    bus.valid_i = 1'b0;
  endtask
  task automatic drain;
    bus.drain_i = 1'b1;
    tick();
    bus.drain_i = 1'b0;
  endtask
  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({d, l});
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.burst_valid_o) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, n >= 200, 0);
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.burst_valid_o && n < 50) begin
      tick();
      n++;
    end
    check(name, bus.burst_valid_o, 1);
  endtask
  // Monitor: pop and compare each transferred beat, and check beats hold while stalled
  always @(negedge clk) begin
    if (hold) begin
      check("hold_valid", bus.burst_valid_o, 1);
      check("hold_data", bus.data_o, hold_d);
      check("hold_last", bus.burst_last_o, hold_l);
    end
    hold   = bus.burst_valid_o && !bus.burst_ready_i && !flush;
    hold_d = bus.data_o;
    hold_l = bus.burst_last_o;
    if (bus.burst_valid_o && bus.burst_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data %0h with no beat expected", bus.data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", bus.data_o, mon_e.d);
        check("beat_last", bus.burst_last_o, mon_e.l);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.push_i = 0; bus.data_i = 0; bus.tag_i = 0; bus.valid_i = 0; bus.valid_tag_i = 0;
    bus.drain_i = 0; bus.burst_ready_i = 0;
`ifdef BURST_BUFFER_FORWARD_EN
    bus.fwd_tag_i = 0;
`endif
    #12;
    check("rst_valid", bus.burst_valid_o, 0);
    check("rst_last", bus.burst_last_o, 0);
    check("rst_full", bus.full_o, 0);
    check("rst_empty", bus.empty_o, 1);
    check("rst_size", bus.size_o, 0);
`ifdef BURST_BUFFER_FORWARD_EN
    check("rst_fwd_hit", bus.fwd_hit_o, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    bus.burst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) expect_beat(32'hA0 + i, i == 3);
    for (int i = 0; i < 4; i++) push(TW'(i), 32'hA0 + i);
    check("t1_size", bus.size_o, 4);
    check("t1_empty", bus.empty_o, 0);
    for (int i = 0; i < 4; i++) commit(TW'(i));
    check("t1_valid_c1", bus.burst_valid_o, 0);
    tick();
    check("t1_valid_c2", bus.burst_valid_o, 1);
    wait_done("t1_done");
    check("t1_size_after", bus.size_o, 0);
    check("t1_empty_after", bus.empty_o, 1);
    for (int i = 0; i < 4; i++) push(TW'(10 + i), 32'hB0 + i);
    for (int i = 1; i < 4; i++) commit(TW'(10 + i));
    repeat (4) tick();
    check("t2_no_burst", bus.burst_valid_o, 0);
    check("t2_size", bus.size_o, 4);
    for (int i = 0; i < 4; i++) expect_beat(32'hB0 + i, i == 3);
    commit(TW'(10));
    wait_done("t2_done");
    for (int i = 0; i < 3; i++) push(TW'(20 + i), 32'hC0 + i);
    commit(TW'(20));
    commit(TW'(21));
    repeat (3) tick();
    check("t3_no_burst", bus.burst_valid_o, 0);
    expect_beat(32'hC0, 0);
    expect_beat(32'hC1, 1);
    drain();
    wait_done("t3_done");
    check("t3_size", bus.size_o, 1);
    commit(TW'(22));
    repeat (4) tick();
    check("t3_drain_cleared", bus.burst_valid_o, 0);
    check("t3_size_kept", bus.size_o, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush_empty", bus.empty_o, 1);
    bus.burst_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(TW'(30 + i), 32'hD0 + i);
    check("t4_full", bus.full_o, 1);
    check("t4_size", bus.size_o, DEPTH);
    push(TW'(63), 32'hEE);
    check("t4_full_drop", bus.size_o, DEPTH);
    for (int i = 0; i < DEPTH; i++) expect_beat(32'hD0 + i, i % 4 == 3);
    for (int i = 0; i < 4; i++) expect_beat(32'hE0 + i, i == 3);
    fork
      begin
        int n = 0;
        while (!stop && n < 400) begin
          bus.burst_ready_i = ~bus.burst_ready_i;
          tick();
          n++;
        end
      end
      begin
        int n = 0;
        for (int i = 0; i < DEPTH; i++) commit(TW'(30 + i));
        while (bus.size_o > 4 && n < 200) begin
          tick();
          n++;
        end
        check("t4_space_timeout", n >= 200, 0);
        for (int i = 0; i < 4; i++) push(TW'(40 + i), 32'hE0 + i);
        for (int i = 0; i < 4; i++) commit(TW'(40 + i));
        wait_done("t4_done");
        stop = 1'b1;
      end
    join
    bus.burst_ready_i = 1'b0;
    tick();
    check("t4_empty", bus.empty_o, 1);
    for (int i = 0; i < 4; i++) push(TW'(50 + i), 32'hF0 + i);
    expect_beat(32'hF0, 0);
    for (int i = 0; i < 4; i++) commit(TW'(50 + i));
    wait_valid("t5_start");
    bus.burst_ready_i = 1'b1;
    tick();
    check("t5_beat2_data", bus.data_o, 32'hF1);
    bus.burst_ready_i = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush_valid", bus.burst_valid_o, 0);
    check("t5_flush_empty", bus.empty_o, 1);
    check("t5_flush_size", bus.size_o, 0);
    check("t5_flush_last", bus.burst_last_o, 0);
    bus.burst_ready_i = 1'b1;
    expect_beat(32'h60, 1);
    push(TW'(60), 32'h60);
    commit(TW'(60));
    drain();
    wait_done("t5_after");
`ifdef BURST_BUFFER_FORWARD_EN
    bus.burst_ready_i = 1'b0;
    bus.fwd_tag_i = TW'(5);
    bus.push_i = 1'b1; bus.tag_i = TW'(5); bus.data_i = 32'h55;
    #1;
    check("t6_same_cycle_miss", bus.fwd_hit_o, 0);
    tick();
    bus.push_i = 1'b0;
    check("t6_hit", bus.fwd_hit_o, 1);
    check("t6_data", bus.fwd_data_o, 32'h55);
    commit(TW'(5));
    expect_beat(32'h55, 1);
    drain();
    wait_valid("t6_start");
    bus.burst_ready_i = 1'b1;
    #1;
    check("t6_hit_while_pulled", bus.fwd_hit_o, 1);
    tick();
    check("t6_miss_after", bus.fwd_hit_o, 0);
    wait_done("t6_done");
`endif
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/validated_burst_buffer.md
# validated_burst_buffer

Parametrised store burst buffer between the load/store unit and the external memory interface. It queues store data tagged with the producing instruction's tag and marks each entry committed individually when its tag is written back. It emits fixed-length bursts to memory over a valid/ready handshake only from committed head entries. An explicit drain request emits a short final burst.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one stored word
- DEPTH, 64, number of entries; power of two, at least 2
- TAG_WIDTH, 6, store tag width
- BURST_LEN, 4, beats per full burst; power of two, at most DEPTH

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of all state; highest priority
- push_i  in  1  enqueue data_i/tag_i
- data_i  in  DATA_WIDTH  store data
- tag_i  in  TAG_WIDTH  store tag
- full_o  out  1  DEPTH live entries
- empty_o  out  1  no live entries
- size_o  out  $clog2(DEPTH)+1  live entry count
- valid_i  in  1  writeback strobe
- valid_tag_i  in  TAG_WIDTH  tag being committed
- drain_i  in  1  request to flush committed entries to memory even if fewer than BURST_LEN
- burst_valid_o  out  1  beat available
- burst_ready_i  in  1  memory accepts beat
- data_o  out  DATA_WIDTH  beat data (head entry)
- burst_last_o  out  1  final beat of current burst
- fwd_tag_i  in  TAG_WIDTH  forwarding lookup tag (macro only)
- fwd_hit_o  out  1  live entry with fwd_tag_i exists (macro only)
- fwd_data_o  out  DATA_WIDTH  data of hit entry (macro only)

## Operation
- Circular storage with $clog2(DEPTH)-bit push/pull pointers that wrap naturally, plus a separate count register.
- Each entry holds data, tag and a committed bit.
- Push:
  - When push_i and !full_o, write at push_ptr, clear its committed bit, advance push_ptr.
  - Push while full is dropped: no state change. Full is sampled before any same-cycle pull.
- Commit: when valid_i, every live entry whose tag equals valid_tag_i sets its committed bit. The caller guarantees tags are unique among live entries. An entry pushed in the same cycle is not matched.
- drain_pending register:
  - Set by drain_i.
  - Cleared when empty_o is high, or when a drain burst completes and the head entry is uncommitted.
- FSM states IDLE, BURST:
  - IDLE -> BURST when the BURST_LEN head entries are all live and committed. beat_count is loaded with BURST_LEN.
  - IDLE -> BURST when drain_pending is set and the head entry is committed. beat_count is loaded with the number of consecutive committed entries from the head, capped at BURST_LEN.
  - In BURST, burst_valid_o = 1 and data_o = head data.
  - A beat transfers when burst_valid_o && burst_ready_i: pull_ptr increments and beat_count decrements.
  - burst_last_o = 1 when beat_count == 1.
  - On the last beat transfer, BURST -> IDLE.
- Burst length is locked on entry to BURST. Later commits do not extend it.
- Simultaneous push and beat transfer: count unchanged, both pointers advance.
- flush_i:
  - Clears pointers, count, all committed bits and drain_pending. FSM goes to IDLE.
  - This applies mid-burst too; the burst is abandoned without a last beat.
- Async reset has the same effect as flush_i.
- Reset values: burst_valid_o 0, burst_last_o 0, full_o 0, empty_o 1, size_o 0, fwd_hit_o 0. data_o and fwd_data_o are don't-care while their qualifier is low.

## Timing
- Push at edge N: size_o and empty_o update after N.
- valid_i in cycle c: the committed bit is set at the end of c. The FSM transitions at the end of c+1, so burst_valid_o rises in cycle c+2 at the earliest.
- Beats stream back-to-back while burst_ready_i is held.
- One IDLE bubble cycle separates consecutive bursts.
- burst_ready_i low holds data_o and burst_last_o stable.
- data_o is a combinational read of the head entry. No extra latency.

## Configuration
- BURST_BUFFER_FORWARD_EN defined:
  - Second combinational read port: a CAM lookup of fwd_tag_i over live entries drives fwd_hit_o/fwd_data_o in the same cycle.
  - A pushed entry is visible from the next cycle.
  - An entry popped this cycle is still visible this cycle.
- Undefined: fwd_* ports are absent and no lookup logic is built.

## Test plan
- Reset, then push tags 0..3 with data 0xA0..0xA3 and commit tags 0..3 -> burst_valid_o two cycles after the last commit; 4 beats 0xA0..0xA3; burst_last_o only on 0xA3; size_o 0 afterwards.
- Push 4 entries, commit tags 1..3 only -> no burst. Commit tag 0 -> full burst starts.
- Push 3, commit 2, assert drain_i -> 2-beat burst with burst_last_o on beat 2; entry 3 remains; drain_pending clears.
- Fill to DEPTH, push again -> full_o 1, extra data discarded. Stream pops and pushes across the pointer wrap with burst_ready_i toggling every cycle -> data order preserved, beats held while burst_ready_i is low.
- flush_i during beat 2 of a burst -> next cycle burst_valid_o 0, empty_o 1, size_o 0; later push/commit works normally.
- With BURST_BUFFER_FORWARD_EN, push tag 5 data 0x55 -> the lookup of tag 5 hits with 0x55 from the next cycle. After that entry is pulled, lookup misses.
